regfile_port_sched: RTL
=======================

Name: regfile_port_sched

Overview:
Sequencer and arbiter for the single-port 16x32 register file, which has one reg_num, one write enable and a combinational read. It serialises multi-operand read requests from decode, up to 3 operands (Rn, Rm, Rs), onto the one port. It also shares that port with writeback, bounding writeback priority so reads cannot starve. It sits between decode/writeback and the register file; the pc and cpsr ports are not handled here.

Parameters:
WB_BURST, 4, maximum consecutive granted writes while a read sequence is pending before one read slot is forced (legal range 1..15)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  reset, synchronous, active-low
rd_req_valid  input  1  decode presents a read request
rd_req_ready  output  1  request accepted when valid&&ready
rd_req_mask  input  3  bit k=1: operand k wanted
rd_req_idx  input  12  operand indices; operand k = bits [4k+3:4k]
rd_rsp_valid  output  1  operand data valid
rd_rsp_ready  input  1  decode consumes response
rd_rsp_data  output  96  operand k data = bits [32k+31:32k]
wb_valid  input  1  writeback write request
wb_ready  output  1  write granted this cycle when valid&&ready
wb_idx  input  4  destination register
wb_data  input  32  write data
rf_reg_num  output  4  register file index
rf_write_en  output  1  register file write enable
rf_data_in  output  32  register file write data
rf_data_out  input  32  register file read data (combinational)
busy  output  1  state != IDLE

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE, pending mask=0, captured data=0, burst_cnt=0.
  - Registered outputs after reset: rd_rsp_valid=0, rd_rsp_data=0.
  - Combinational outputs with wb_valid=0: rf_write_en=0, rf_reg_num=0, rf_data_in=0, busy=0.
  - Reset mid-sequence discards all captured operands; no response is issued.
- FSM: IDLE, READ, RESP.
  - IDLE: rd_req_ready=1 (only state where it is 1). On accept, latch mask and indices and clear the data slots.
    - Mask!=0: go to READ.
    - Mask==0: go to RESP with data all zero.
  - READ: each cycle is either a write slot or a read slot.
    - Read slot: rf_reg_num = index of the lowest set pending bit. At the clock edge, rf_data_out goes into that operand's slot and the bit clears.
    - When the last bit clears, go to RESP.
  - RESP: rd_rsp_valid=1; rd_rsp_data stays stable until rd_rsp_ready. On valid&&ready go to IDLE. A new request is not accepted in the same cycle.
- Unmasked operand slots read as 0 in rd_rsp_data.
- Latency with no writes: accept at cycle T, reads at T+1..T+n, rd_rsp_valid at T+n+1 (n = popcount(mask)). Mask==0 gives rd_rsp_valid at T+1.
- Write arbitration: wb_ready = !(state==READ && burst_cnt==WB_BURST). wb_ready does not depend on wb_valid.
  - Granted write (wb_valid&&wb_ready): rf_write_en=1, rf_reg_num=wb_idx, rf_data_in=wb_data. A write slot performs no read.
  - Writes are always granted in IDLE and RESP.
- burst_cnt:
  - Increments on each granted write while in READ.
  - Clears on every read slot and on any exit from READ.
  - Never exceeds WB_BURST.
- Register hazards:
  - A write to register r granted before r's read slot returns the new value, because the register file write is visible the next cycle.
  - A write granted after r's read slot does not update the captured operand; decode handles that hazard.
- Duplicate indices in one request are each read separately and both slots get the same value.
- Index 15 is read and written like any other register; there is no special case.
- Inputs rd_req_idx and rd_req_mask are ignored outside the accept cycle.

Test Plan:
- Reset: regs preloaded R1=0x11, R2=0x22, R3=0x33. Mask=3'b111, idx={3,2,1}, no wb → rf_reg_num 1,2,3 on T+1..T+3; rsp_valid at T+4, data={0x33,0x22,0x11}. Hold rsp_ready=0 for 3 cycles → data stable; ready=1 → IDLE, busy=0.
- Mask=3'b000 → rsp_valid at T+1, data=0, rf_write_en never set.
- Mask=3'b101, idx0=5, idx2=7 → two read slots only; slot1=0, slot0=R5, slot2=R7.
- WB_BURST=4, mask=3'b001 idx0=9, wb_valid held 1 writing R4=0xA0..0xA5 → 4 writes granted, wb_ready=0 for one cycle (R9 read), then writes resume; rsp_valid follows.
- Forwarding order: wb_valid writes R6=0xDEAD in the accept cycle+1 while mask=3'b001 idx0=6 → captured 0xDEAD.
- Assert reset=0 in READ after one capture → next cycle IDLE, rd_rsp_valid=0, rd_rsp_data=0; a new request completes normally.

Source files
------------

// File: rtl/regfile_port_sched.sv
// Serialises up to three operand reads from decode onto the single
// register-file port and shares that port with writeback.
//
// Ports:
//   clk, reset       - rising-edge clock, synchronous active-low reset
//   rd_req_*         - decode read request (mask of operands, 3x4-bit indices)
//   rd_rsp_*         - gathered operand data (3x32 bits), held until consumed
//   wb_*             - writeback write request, granted via wb_ready
//   rf_*             - single register-file port (combinational read)
//   busy             - sequencer not idle
module regfile_port_sched #(
    parameter int unsigned WB_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_req_valid,
    output logic        rd_req_ready,
    input  logic [2:0]  rd_req_mask,
    input  logic [11:0] rd_req_idx,
    output logic        rd_rsp_valid,
    input  logic        rd_rsp_ready,
    output logic [95:0] rd_rsp_data,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [3:0]  wb_idx,
    input  logic [31:0] wb_data,
    output logic [3:0]  rf_reg_num,
    output logic        rf_write_en,
    output logic [31:0] rf_data_in,
    input  logic [31:0] rf_data_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RESP
    } state_t;

    localparam logic [3:0] BURST_MAX = 4'(WB_BURST);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  pend;
    logic [11:0] idx_q;
    logic [95:0] data_q;
    logic [3:0]  burst_cnt;

    logic        wb_grant;
    logic        rd_slot;
    logic [1:0]  sel;
    logic [3:0]  sel_idx;
    logic [2:0]  pend_clr;

    // Lowest pending operand is served first.
    always_comb begin
        sel = 2'd2;
        if (pend[0]) begin
            sel = 2'd0;
        end else if (pend[1]) begin
            sel = 2'd1;
        end
    end

    assign sel_idx  = idx_q[{sel, 2'b00} +: 4];
    assign pend_clr = pend & ~(3'b001 << sel);

    // Writeback loses the port only once it has used up its burst
    // allowance while a read sequence is waiting.
    assign wb_ready = !(state == READ && burst_cnt == BURST_MAX);
    assign wb_grant = wb_valid && wb_ready;
    assign rd_slot  = (state == READ) && !wb_grant;

    always_comb begin
        rf_write_en = 1'b0;
        rf_reg_num  = 4'd0;
        rf_data_in  = 32'd0;
        if (wb_grant) begin
            rf_write_en = 1'b1;
            rf_reg_num  = wb_idx;
            rf_data_in  = wb_data;
        end else if (rd_slot) begin
            rf_reg_num = sel_idx;
        end
    end

    assign rd_req_ready = (state == IDLE);
    assign rd_rsp_valid = (state == RESP);
    assign rd_rsp_data  = data_q;
    assign busy         = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rd_req_valid) begin
                    state_nxt = (rd_req_mask != 3'b000) ? READ : RESP;
                end
            end
            READ: begin
                if (rd_slot && pend_clr == 3'b000) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rd_rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            pend      <= 3'b000;
            idx_q     <= 12'd0;
            data_q    <= 96'd0;
            burst_cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    burst_cnt <= 4'd0;
                    if (rd_req_valid) begin
                        pend   <= rd_req_mask;
                        idx_q  <= rd_req_idx;
                        data_q <= 96'd0;
                    end
                end
                READ: begin
                    if (rd_slot) begin
                        data_q[{sel, 5'b00000} +: 32] <= rf_data_out;
                        pend      <= pend_clr;
                        burst_cnt <= 4'd0;
                    end else begin
                        burst_cnt <= burst_cnt + 4'd1;
                    end
                end
                default: burst_cnt <= 4'd0;
            endcase
        end
    end

endmodule
